// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard/branch inputs, instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_offset;
    logic [31:0] instr_in;
    logic [63:0] pc_if;
    logic [31:0] instr_id;
    logic [63:0] pc_id;
    logic [63:0] pc4_id;
    logic        valid_id;
    modport master (
        input  stall, br_taken, br_offset, instr_in,
        output pc_if, instr_id, pc_id, pc4_id, valid_id
    );
    modport slave (
        output stall, br_taken, br_offset, instr_in,
        input  pc_if, instr_id, pc_id, pc4_id, valid_id
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 PC register, instruction fetch and IF/ID pipeline register
module fetch_stage #(
    parameter bit          DELAY_SLOT = 1'b1,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    logic [63:0] pc_seq;
    logic [63:0] target;
    logic        br_eff;
    logic        squash;

    assign pc_seq = bus.pc_if + 64'd4;
    assign target = bus.pc_id + (bus.br_offset << 2);
    assign br_eff = bus.br_taken & bus.valid_id & ~bus.stall;
    assign squash = br_eff & ~DELAY_SLOT;

    // PC and IF/ID update: reset beats stall, stall freezes everything, a taken branch redirects the PC
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc_if    <= RESET_PC;
            bus.instr_id <= NOP_INSTR;
            bus.pc_id    <= 64'd0;
            bus.pc4_id   <= 64'd4;
            bus.valid_id <= 1'b0;
        end else if (!bus.stall) begin
            bus.pc_if    <= br_eff ? target : pc_seq;
            bus.instr_id <= squash ? NOP_INSTR : bus.instr_in;
            bus.pc_id    <= bus.pc_if;
            bus.pc4_id   <= pc_seq;
            bus.valid_id <= ~squash;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table, corner sequences and randomized model check of fetch_stage
module tb_fetch_stage;
    localparam logic [31:0] NOP     = 32'hD503201F;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] key = 32'd0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fetch_stage_if b0 ();
    fetch_stage_if b1 ();
    fetch_stage_if b2 ();

    fetch_stage #(.DELAY_SLOT(1'b0)) d0 (.clk(clk), .reset(reset), .bus(b0.master));
    fetch_stage #(.DELAY_SLOT(1'b1)) d1 (.clk(clk), .reset(reset), .bus(b1.master));
    fetch_stage #(.DELAY_SLOT(1'b1), .RESET_PC(WRAP_PC)) d2 (.clk(clk), .reset(reset), .bus(b2.master));

    assign b0.instr_in = b0.pc_if[31:0] ^ key;
    assign b1.instr_in = b1.pc_if[31:0] ^ key;
    assign b2.instr_in = b2.pc_if[31:0] ^ key;

    logic [63:0] o_pc[3], o_pid[3], o_p4[3];
    logic [31:0] o_in[3];
    logic        o_v[3];
    assign o_pc  = '{b0.pc_if, b1.pc_if, b2.pc_if};
    assign o_pid = '{b0.pc_id, b1.pc_id, b2.pc_id};
    assign o_p4  = '{b0.pc4_id, b1.pc4_id, b2.pc4_id};
    assign o_in  = '{b0.instr_id, b1.instr_id, b2.instr_id};
    assign o_v   = '{b0.valid_id, b1.valid_id, b2.valid_id};

    typedef struct {
        logic        r, s, b;
        logic [63:0] off;
        logic [63:0] pc;
        logic [31:0] ins;
        logic [63:0] pid, p4;
        logic        v;
    } vec_t;
    vec_t tbl[18];

    logic [63:0] m_pc[3], m_pid[3], m_p4[3];
    logic [31:0] m_in[3];
    logic        m_v[3];
    bit          ds[3] = '{1'b0, 1'b1, 1'b1};
    logic [63:0] rp[3] = '{64'd0, 64'd0, WRAP_PC};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(logic r, logic s, logic b, logic [63:0] off);
        reset = r;
        b0.stall = s; b1.stall = s; b2.stall = s;
        b0.br_taken = b; b1.br_taken = b; b2.br_taken = b;
        b0.br_offset = off; b1.br_offset = off; b2.br_offset = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one edge of the fetch stage expressed as PC arithmetic on instruction addresses
    task automatic model_step(logic r, logic s, logic b, logic [63:0] off);
        bit          take;
        logic [63:0] nxt;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_pc[k] = rp[k]; m_in[k] = NOP; m_pid[k] = 64'd0; m_p4[k] = 64'd4; m_v[k] = 1'b0;
            end else if (!s) begin
                take = b && m_v[k];
                nxt = take ? m_pid[k] + off * 64'd4 : m_pc[k] + 64'd4;
                m_in[k] = (take && !ds[k]) ? NOP : (m_pc[k][31:0] ^ key);
                m_v[k] = !(take && !ds[k]);
                m_pid[k] = m_pc[k];
                m_p4[k] = m_pc[k] + 64'd4;
                m_pc[k] = nxt;
            end
        end
    endtask

    initial begin
        logic        r, s, b;
        logic [63:0] off;
        apply(1'b1, 1'b0, 1'b0, 64'd0);
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'd0,    64'd0,  NOP,    64'd0,  64'd4,  1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd4,  32'd0,  64'd0,  64'd4,  1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd8,  32'd4,  64'd4,  64'd8,  1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 64'd0,    64'd8,  32'd4,  64'd4,  64'd8,  1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 64'd0,    64'd8,  32'd4,  64'd4,  64'd8,  1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd12, 32'd8,  64'd8,  64'd12, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 64'd10,   64'd48, 32'd12, 64'd12, 64'd16, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd52, 32'd48, 64'd48, 64'd52, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 64'd0,    64'd0,  NOP,    64'd0,  64'd4,  1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd4,  32'd0,  64'd0,  64'd4,  1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd8,  32'd4,  64'd4,  64'd8,  1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd12, 32'd8,  64'd8,  64'd12, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b1, -64'sd2,  64'd12, 32'd8,  64'd8,  64'd12, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, -64'sd2,  64'd0,  32'd12, 64'd12, 64'd16, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 64'd1,    64'd16, 32'd0,  64'd0,  64'd4,  1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 64'd0,    64'd20, 32'd16, 64'd16, 64'd20, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 64'd5,    64'd0,  NOP,    64'd0,  64'd4,  1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 64'd5,    64'd4,  32'd0,  64'd0,  64'd4,  1'b1};
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].off);
            tick();
            chk($sformatf("vec%0d pc_if", i), b1.pc_if, tbl[i].pc);
            chk($sformatf("vec%0d instr_id", i), {32'd0, b1.instr_id}, {32'd0, tbl[i].ins});
            chk($sformatf("vec%0d pc_id", i), b1.pc_id, tbl[i].pid);
            chk($sformatf("vec%0d pc4_id", i), b1.pc4_id, tbl[i].p4);
            chk($sformatf("vec%0d valid_id", i), {63'd0, b1.valid_id}, {63'd0, tbl[i].v});
        end

        apply(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk("wrap reset pc_if", b2.pc_if, WRAP_PC);
        chk("ds0 reset valid_id", {63'd0, b0.valid_id}, 64'd0);
        apply(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk("wrap pc_if", b2.pc_if, 64'd0);
        chk("wrap pc_id", b2.pc_id, WRAP_PC);
        chk("wrap pc4_id", b2.pc4_id, 64'd0);
        chk("wrap instr_id", {32'd0, b2.instr_id}, 64'hFFFF_FFFC);
        tick();
        tick();
        chk("ds0 pre-branch pc_if", b0.pc_if, 64'd12);
        chk("ds0 pre-branch pc_id", b0.pc_id, 64'd8);
        apply(1'b0, 1'b0, 1'b1, 64'd10);
        tick();
        chk("ds0 branch pc_if", b0.pc_if, 64'd48);
        chk("ds0 squash instr_id", {32'd0, b0.instr_id}, {32'd0, NOP});
        chk("ds0 squash valid_id", {63'd0, b0.valid_id}, 64'd0);
        chk("ds0 squash pc_id", b0.pc_id, 64'd12);
        tick();
        chk("ds0 held br pc_if", b0.pc_if, 64'd52);
        chk("ds0 held br pc_id", b0.pc_id, 64'd48);
        chk("ds0 held br instr_id", {32'd0, b0.instr_id}, 64'd48);
        chk("ds0 held br valid_id", {63'd0, b0.valid_id}, 64'd1);

        key = $urandom;
        apply(1'b1, 1'b0, 1'b0, 64'd0);
        model_step(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99) < 3;
            s = $urandom_range(0, 3) == 0;
            b = $urandom_range(0, 9) < 4;
            off = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : 64'(int'($urandom_range(0, 40)) - 20);
            apply(r, s, b, off);
            model_step(r, s, b, off);
            tick();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rnd%0d d%0d pc_if", i, k), o_pc[k], m_pc[k]);
                chk($sformatf("rnd%0d d%0d instr_id", i, k), {32'd0, o_in[k]}, {32'd0, m_in[k]});
                chk($sformatf("rnd%0d d%0d pc_id", i, k), o_pid[k], m_pid[k]);
                chk($sformatf("rnd%0d d%0d pc4_id", i, k), o_p4[k], m_p4[k]);
                chk($sformatf("rnd%0d d%0d valid_id", i, k), {63'd0, o_v[k]}, {63'd0, m_v[k]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
